// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
        logic                    misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries. The head output is registered state; when
// empty it keeps presenting the last entry that was at the head.
module fetch_queue
    import if_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int AW     = $clog2(QDEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [QDEPTH];
    fetch_entry_t  last_q;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(QDEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '{pc: '0, instr: NOP, misalign: 1'b0};
        end else begin
            // Remember what was shown so the outputs hold once the queue drains.
            if (!empty)
                last_q <= mem[rd_ptr];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_entry;
    end

    assign head = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, one-deep in-flight tracking over a
// synchronous IMEM port, and a decoupling queue toward decode.
// Optional macro IF_MISALIGN_TRAP_EN enables misaligned-redirect trapping.
module fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic            if_misalign_o
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int OW = CW + 1;

    logic [XLEN-1:0] pc_q, inflight_pc_q, target;
    logic            inflight_q, halted, pop, push;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occ;
    logic            q_empty, q_full;
    fetch_entry_t    push_entry, head;

    assign if_valid_o = !q_empty;
    // A handshake coinciding with a redirect is void: decode is being killed.
    assign pop        = if_valid_o && id_ready_i && !redirect_i;

    // Occupancy once this cycle's pop and the outstanding response settle.
    assign occ        = OW'(count) + OW'(inflight_q) - OW'(pop);
    assign imem_req_o = rst_ni && !redirect_i && !halted && (occ < OW'(QDEPTH));
    assign imem_addr_o = {pc_q[XLEN-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= imem_req_o;
            if (imem_req_o)
                inflight_pc_q <= imem_addr_o;
            if (redirect_i)
                pc_q <= target;
            else if (imem_req_o)
                pc_q <= pc_q + XLEN'(4);
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic            trap_q, halted_q;
    logic [XLEN-1:0] trap_pc_q;

    assign target = redirect_pc_i;
    assign halted = halted_q;

    // A misaligned redirect injects one trap entry next cycle and stalls
    // fetch until a later redirect re-arms it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trap_q    <= 1'b0;
            halted_q  <= 1'b0;
            trap_pc_q <= '0;
        end else if (redirect_i) begin
            trap_q    <= |redirect_pc_i[1:0];
            halted_q  <= |redirect_pc_i[1:0];
            trap_pc_q <= redirect_pc_i;
        end else begin
            trap_q <= 1'b0;
        end
    end

    assign push       = (inflight_q || trap_q) && !redirect_i;
    assign push_entry = trap_q ? '{pc: trap_pc_q, instr: NOP, misalign: 1'b1}
                               : '{pc: inflight_pc_q, instr: imem_rdata_i, misalign: 1'b0};
    assign if_misalign_o = if_valid_o && head.misalign;
`else
    logic unused_trap;

    assign target        = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign halted        = 1'b0;
    assign push          = inflight_q && !redirect_i;
    assign push_entry    = '{pc: inflight_pc_q, instr: imem_rdata_i, misalign: 1'b0};
    assign if_misalign_o = 1'b0;
    assign unused_trap   = ^{head.misalign, redirect_pc_i[1:0]};
`endif

    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_i),
        .head       (head),
        .count      (count),
        .empty      (q_empty),
        .full       (q_full)
    );

    logic unused_full;
    assign unused_full = q_full;

    assign if_pc_o    = head.pc;
    assign if_instr_o = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle checks of the fetch timing plus a scoreboard of
// the PC/instruction stream handed to decode. Also covers IF_MISALIGN_TRAP_EN.
module tb_fetch_unit;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect, id_ready;
    logic [31:0] redirect_pc;
    logic        imem_req, if_valid, if_misalign;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;

    logic        redirect_w, id_ready_w;
    logic [31:0] redirect_pc_w;
    logic        imem_req_w, if_valid_w, if_misalign_w;
    logic [31:0] imem_addr_w, imem_rdata_w, if_pc_w, if_instr_w;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    bit   sb_en = 1'b0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
        .if_valid_o(if_valid), .id_ready_i(id_ready), .if_pc_o(if_pc),
        .if_instr_o(if_instr), .if_misalign_o(if_misalign)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w),
        .imem_req_o(imem_req_w), .imem_addr_o(imem_addr_w), .imem_rdata_i(imem_rdata_w),
        .if_valid_o(if_valid_w), .id_ready_i(id_ready_w), .if_pc_o(if_pc_w),
        .if_instr_o(if_instr_w), .if_misalign_o(if_misalign_w)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // IMEM model: address-tagged word one cycle after the request.
    always @(posedge clk) begin
        if (imem_req)   imem_rdata   <= tag(imem_addr);
        if (imem_req_w) imem_rdata_w <= tag(imem_addr_w);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_load(input logic [31:0] base, input bit mis);
        sb_q.delete();
        if (mis)
            sb_q.push_back('{base, NOP_W, 1'b1});
        else
            for (int i = 0; i < 64; i++)
                sb_q.push_back('{base + 32'(4 * i), tag(base + 32'(4 * i)), 1'b0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted entry must be the next one the bench predicted.
    always @(negedge clk) begin
        if (sb_en && rst_n && if_valid && id_ready && !redirect) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_entry", if_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_instr", if_instr, e.instr);
                chk("sb_misalign", if_misalign, e.mis);
            end
        end
    end

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        redirect_w = 1'b0; redirect_pc_w = '0; id_ready_w = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, NOP_W);
        chk("rst_misalign", if_misalign, 0);

        // Reset release and streaming start
        tick(); rst_n = 1'b1; sb_load(32'h0, 1'b0); sb_en = 1'b1; #1;
        chk("c0_req", imem_req, 1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", if_valid, 0);
        chk("wrap_c0_addr", imem_addr_w, 32'hFFFF_FFF8);
        tick(); #1;
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", if_valid, 0);
        chk("wrap_c1_addr", imem_addr_w, 32'hFFFF_FFFC);
        tick(); #1;
        chk("c2_addr", imem_addr, 32'h8);
        chk("c2_valid", if_valid, 1);
        chk("c2_pc", if_pc, 32'h0);
        chk("wrap_c2_addr", imem_addr_w, 32'h0);
        chk("wrap_c2_pc", if_pc_w, 32'hFFFF_FFF8);
        chk("wrap_c2_instr", if_instr_w, tag(32'hFFFF_FFF8));

        // Back-pressure: 6 cycles of id_ready low from cycle 3
        tick(); id_ready = 1'b0; #1;
        chk("bp_req", imem_req, 0);
        chk("bp_pc", if_pc, 32'h4);
        chk("wrap_c3_pc", if_pc_w, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            if (i == 0) chk("wrap_c4_pc", if_pc_w, 32'h0);
            chk("bp_hold_req", imem_req, 0);
            chk("bp_hold_valid", if_valid, 1);
            chk("bp_hold_pc", if_pc, 32'h4);
        end
        tick(); id_ready = 1'b1; #1;
        chk("bp_resume_req", imem_req, 1);
        chk("bp_resume_addr", imem_addr, 32'hC);
        for (int i = 1; i <= 5; i++) begin
            tick(); #1;
            chk("stream_addr", imem_addr, 32'hC + 32'(4 * i));
        end

        // Redirect with occupied queue and a response in flight
        tick(); id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100; sb_load(32'h100, 1'b0); #1;
        chk("rd1_req", imem_req, 0);
        tick(); redirect = 1'b0; id_ready = 1'b1; #1;
        chk("rd1_n1_req", imem_req, 1);
        chk("rd1_n1_addr", imem_addr, 32'h100);
        chk("rd1_n1_valid", if_valid, 0);
        tick(); #1;
        chk("rd1_n2_valid", if_valid, 0);
        tick(); #1;
        chk("rd1_n3_valid", if_valid, 1);
        chk("rd1_n3_pc", if_pc, 32'h100);
        chk("rd1_n3_instr", if_instr, tag(32'h100));
        tick(); #1;
        chk("rd1_n4_pc", if_pc, 32'h104);

        // Redirect with a same-cycle pop, then back-to-back redirect
        tick(); redirect = 1'b1; redirect_pc = 32'h180; sb_load(32'h180, 1'b0); #1;
        chk("rd2_valid", if_valid, 1);
        chk("rd2_req", imem_req, 0);
        tick(); redirect_pc = 32'h200; sb_load(32'h200, 1'b0); #1;
        chk("rd3_req", imem_req, 0);
        tick(); redirect = 1'b0; #1;
        chk("rd3_n1_addr", imem_addr, 32'h200);
        chk("rd3_n1_valid", if_valid, 0);
        tick(); #1;
        chk("rd3_n2_valid", if_valid, 0);
        tick(); #1;
        chk("rd3_n3_pc", if_pc, 32'h200);
        repeat (2) tick();

        // Misaligned redirect target
        tick(); redirect = 1'b1; redirect_pc = 32'h102;
`ifdef IF_MISALIGN_TRAP_EN
        sb_load(32'h102, 1'b1);
`else
        sb_load(32'h100, 1'b0);
`endif
        #1;
        tick(); redirect = 1'b0; #1;
`ifdef IF_MISALIGN_TRAP_EN
        chk("mis_n1_req", imem_req, 0);
        chk("mis_n1_valid", if_valid, 0);
        tick(); #1;
        chk("mis_n2_valid", if_valid, 1);
        chk("mis_n2_pc", if_pc, 32'h102);
        chk("mis_n2_instr", if_instr, NOP_W);
        chk("mis_n2_flag", if_misalign, 1);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("mis_halt_req", imem_req, 0);
            chk("mis_halt_valid", if_valid, 0);
        end
        tick(); redirect = 1'b1; redirect_pc = 32'h300; sb_load(32'h300, 1'b0); #1;
        tick(); redirect = 1'b0; #1;
        chk("mis_resume_req", imem_req, 1);
        chk("mis_resume_addr", imem_addr, 32'h300);
`else
        chk("mis_n1_req", imem_req, 1);
        chk("mis_n1_addr", imem_addr, 32'h100);
        tick(); tick(); #1;
        chk("mis_n3_valid", if_valid, 1);
        chk("mis_n3_pc", if_pc, 32'h100);
        chk("mis_n3_flag", if_misalign, 0);
`endif
        repeat (3) tick();

        // Asynchronous reset mid-stream
        @(posedge clk); #3; rst_n = 1'b0; #1;
        chk("arst_valid", if_valid, 0);
        chk("arst_req", imem_req, 0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, NOP_W);
        tick(); rst_n = 1'b1; sb_load(32'h0, 1'b0); #1;
        chk("arst_c0_addr", imem_addr, 32'h0);
        chk("arst_c0_req", imem_req, 1);
        tick(); tick(); #1;
        chk("arst_c2_valid", if_valid, 1);
        chk("arst_c2_pc", if_pc, 32'h0);
        repeat (4) tick();

        sb_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
